// File: rtl/board_io_ctrl.sv
// Board I/O front end: PLL-lock reset sequencer, button debounce with press interrupts,
// and synchronised slide switches.
module board_io_ctrl #(
   parameter int unsigned NUM_BTN    = 1,
   parameter int unsigned NUM_SW     = 16,
   parameter int unsigned DB_CYCLES  = 1000000,
   parameter int unsigned RST_CYCLES = 16,
   parameter string       IRQ_MODE   = "PULSE"
) (
   input  logic               clk_i,
   input  logic               arstn_i,
   input  logic               pll_locked_i,
   input  logic [NUM_BTN-1:0] btn_i,
   input  logic [NUM_SW-1:0]  sw_i,
   input  logic [NUM_BTN-1:0] irq_ack_i,
   output logic               srst_o,
   output logic [NUM_BTN-1:0] btn_o,
   output logic [NUM_BTN-1:0] irq_o,
   output logic [NUM_SW-1:0]  sw_o
);

   localparam int unsigned DbW       = $clog2(DB_CYCLES + 1);
   localparam int unsigned RstW      = $clog2(RST_CYCLES + 1);
   localparam int unsigned SyncW     = 1 + NUM_BTN + NUM_SW;
   localparam bit          LevelMode = (IRQ_MODE == "LEVEL");

   typedef enum logic [1:0] {StHold, StStretch, StRun} state_e;

   logic [SyncW-1:0]              sync1_q, sync1_d, sync2_q, sync2_d;
   state_e                        state_q, state_d;
   logic [RstW-1:0]               rcnt_q, rcnt_d;
   logic                          srst_q, srst_d;
   logic [NUM_BTN-1:0]            stable_q, stable_d;
   logic [NUM_BTN-1:0][DbW-1:0]   db_cnt_q, db_cnt_d;
   logic [NUM_BTN-1:0]            irq_q, irq_d;
   logic [NUM_BTN-1:0]            rise;

   logic               lock_s;
   logic [NUM_BTN-1:0] btn_s;

   // Packed as {lock, buttons, switches} so one pair of flops covers every async input.
   assign lock_s = sync2_q[SyncW-1];
   assign btn_s  = sync2_q[NUM_SW +: NUM_BTN];

   always_comb begin
      sync1_d = {pll_locked_i, btn_i, sw_i};
      sync2_d = sync1_q;
   end

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      unique case (state_q)
         StHold: begin
            if (lock_s) begin
               state_d = StStretch;
               rcnt_d  = '0;
            end
         end
         StStretch: begin
            if (rcnt_q != RstW'(RST_CYCLES)) rcnt_d = rcnt_q + RstW'(1);
            // Loss of lock takes priority over stretch completion.
            if (!lock_s) state_d = StHold;
            else if (rcnt_q == RstW'(RST_CYCLES - 1)) state_d = StRun;
         end
         StRun: begin
            if (!lock_s) state_d = StHold;
         end
         default: state_d = StHold;
      endcase
      srst_d = (state_d != StRun);
   end

   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (btn_s[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
            stable_d[i] = btn_s[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
         end
      end
   end

   assign rise = stable_d & ~stable_q & {NUM_BTN{~srst_q}};

   always_comb begin
      irq_d = '0;
      if (!srst_q) begin
         // A new rise wins over a coincident ack in LEVEL mode.
         irq_d = LevelMode ? (rise | (irq_q & ~irq_ack_i)) : rise;
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         state_q  <= StHold;
         rcnt_q   <= '0;
         srst_q   <= 1'b1;
         stable_q <= '0;
         db_cnt_q <= '0;
         irq_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
         srst_q   <= srst_d;
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
         irq_q    <= irq_d;
      end
   end

   assign srst_o = srst_q;
   assign btn_o  = stable_q;
   assign irq_o  = irq_q & {NUM_BTN{~srst_q}};
   assign sw_o   = sync2_q[NUM_SW-1:0];

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: PULSE and LEVEL instances share stimulus; directed scenarios
// use hand-derived edge counts, the random run uses a history-based reference model.
module tb_board_io_ctrl;

   localparam int unsigned NB  = 2;
   localparam int unsigned NS  = 16;
   localparam int unsigned DB  = 4;
   localparam int unsigned RST = 4;
   localparam int          HMAX = 8192;

   logic          clk = 1'b0;
   logic          arstn;
   logic          pll;
   logic [NB-1:0] btn;
   logic [NS-1:0] sw;
   logic [NB-1:0] ack;

   logic          srst_p, srst_l;
   logic [NB-1:0] btn_o_p, btn_o_l, irq_p, irq_l;
   logic [NS-1:0] sw_o_p, sw_o_l;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   board_io_ctrl #(
      .NUM_BTN(NB), .NUM_SW(NS), .DB_CYCLES(DB), .RST_CYCLES(RST), .IRQ_MODE("PULSE")
   ) u_pulse (
      .clk_i(clk), .arstn_i(arstn), .pll_locked_i(pll), .btn_i(btn), .sw_i(sw),
      .irq_ack_i(ack), .srst_o(srst_p), .btn_o(btn_o_p), .irq_o(irq_p), .sw_o(sw_o_p)
   );

   board_io_ctrl #(
      .NUM_BTN(NB), .NUM_SW(NS), .DB_CYCLES(DB), .RST_CYCLES(RST), .IRQ_MODE("LEVEL")
   ) u_level (
      .clk_i(clk), .arstn_i(arstn), .pll_locked_i(pll), .btn_i(btn), .sw_i(sw),
      .irq_ack_i(ack), .srst_o(srst_l), .btn_o(btn_o_l), .irq_o(irq_l), .sw_o(sw_o_l)
   );

   // Reference model: raw input history per edge since reset release (edge 1 = first).
   // A signal seen by the core logic at edge k is the raw sample from edge k-2.
   logic          raw_lock [HMAX];
   logic [NB-1:0] raw_btn  [HMAX];
   logic [NS-1:0] raw_sw   [HMAX];
   int            m_n;
   int            m_lock_run;
   logic          m_srst;
   logic [NB-1:0] m_stable, m_pend, m_irq_p, m_irq_l;
   int            m_last_flip [NB];
   logic [NS-1:0] m_sw;

   task automatic model_reset();
      m_n        = 0;
      m_lock_run = 0;
      m_srst     = 1'b1;
      m_stable   = '0;
      m_pend     = '0;
      m_irq_p    = '0;
      m_irq_l    = '0;
      m_sw       = '0;
      for (int i = 0; i < NB; i++) m_last_flip[i] = 0;
   endtask

   task automatic model_step();
      logic srst_prev, seen, flip, rise;
      int   e;
      if (m_n < HMAX - 1) m_n++;
      raw_lock[m_n] = pll;
      raw_btn[m_n]  = btn;
      raw_sw[m_n]   = sw;
      srst_prev = m_srst;
      // Released from reset once the seen lock has been high for RST+1 consecutive edges.
      seen       = (m_n >= 3) ? raw_lock[m_n-2] : 1'b0;
      m_lock_run = seen ? m_lock_run + 1 : 0;
      m_srst     = (m_lock_run < RST + 1);
      for (int i = 0; i < NB; i++) begin
         // Stable value flips once DB consecutive seen samples since the last flip differ.
         flip = (m_n - m_last_flip[i] >= DB);
         for (int j = 0; j < DB; j++) begin
            e    = m_n - j;
            seen = (e >= 3) ? raw_btn[e-2][i] : 1'b0;
            if (seen == m_stable[i]) flip = 1'b0;
         end
         rise = 1'b0;
         if (flip) begin
            m_stable[i]    = ~m_stable[i];
            m_last_flip[i] = m_n;
            rise           = m_stable[i] & ~srst_prev;
         end
         m_irq_p[i] = rise & ~m_srst;
         if (srst_prev) m_pend[i] = 1'b0;
         else           m_pend[i] = rise | (m_pend[i] & ~ack[i]);
         m_irq_l[i] = m_pend[i] & ~m_srst;
      end
      m_sw = (m_n >= 2) ? raw_sw[m_n-1] : '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset(input logic lock);
      arstn = 1'b0;
      model_reset();
      pll = lock;
      btn = '0;
      sw  = '0;
      ack = '0;
      @(posedge clk);
      #3;
      arstn = 1'b1;
   endtask

   task automatic test_reset();
      arstn = 1'b0;
      pll   = 1'b1;
      btn   = '1;
      sw    = '1;
      ack   = '0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({srst_p, srst_l} !== 2'b11) begin
         errors++;
         $display("FAIL reset_srst: got %b expected 11", {srst_p, srst_l});
      end
      checks++;
      if ({btn_o_p, btn_o_l, irq_p, irq_l, sw_o_p, sw_o_l} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: btn=%b/%b irq=%b/%b sw=%h/%h expected all 0",
                  btn_o_p, btn_o_l, irq_p, irq_l, sw_o_p, sw_o_l);
      end
   endtask

   task automatic test_lock_timing();
      logic exp;
      do_reset(1'b1);
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp = (e < 7);
         checks++;
         if ({srst_p, srst_l} !== {exp, exp}) begin
            errors++;
            $display("FAIL lock_release edge %0d: srst=%b expected %b", e, srst_p, exp);
         end
      end
      pll = 1'b0;
      repeat (3) tick();
      pll = 1'b1;
      checks++;
      if ({srst_p, srst_l} !== 2'b11) begin
         errors++;
         $display("FAIL lock_loss: srst=%b after 3 cycles expected 1", srst_p);
      end
      for (int t = 1; t <= 8; t++) begin
         tick();
         exp = (t < 7);
         checks++;
         if ({srst_p, srst_l} !== {exp, exp}) begin
            errors++;
            $display("FAIL lock_restretch t=%0d: srst=%b expected %b", t, srst_p, exp);
         end
      end
   endtask

   task automatic test_clean_press();
      btn[0] = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         checks++;
         if (btn_o_p[0] !== (t >= 6) || irq_p[0] !== (t == 6)) begin
            errors++;
            $display("FAIL press t=%0d: btn_o=%b irq=%b expected %b %b",
                     t, btn_o_p[0], irq_p[0], (t >= 6), (t == 6));
         end
      end
      btn[0] = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         checks++;
         if (btn_o_p[0] !== (t < 6) || irq_p[0] !== 1'b0) begin
            errors++;
            $display("FAIL release t=%0d: btn_o=%b irq=%b expected %b 0",
                     t, btn_o_p[0], irq_p[0], (t < 6));
         end
      end
   endtask

   task automatic test_bounce();
      int irqs = 0;
      int early_hi = 0;
      btn[1] = 1'b1;
      repeat (2) begin tick(); irqs += irq_p[1]; early_hi += btn_o_p[1]; end
      btn[1] = 1'b0;
      repeat (2) begin tick(); irqs += irq_p[1]; early_hi += btn_o_p[1]; end
      btn[1] = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         irqs += irq_p[1];
         checks++;
         if (btn_o_p[1] !== (t >= 6)) begin
            errors++;
            $display("FAIL bounce t=%0d: btn_o[1]=%b expected %b", t, btn_o_p[1], (t >= 6));
         end
      end
      checks++;
      if (early_hi != 0 || irqs != 1) begin
         errors++;
         $display("FAIL bounce_irq: early highs %0d irqs %0d expected 0 and 1", early_hi, irqs);
      end
   endtask

   task automatic test_level();
      ack = 2'b11;
      tick();
      ack = 2'b00;
      tick();
      checks++;
      if (irq_l !== 2'b00) begin
         errors++;
         $display("FAIL level_clear_all: irq=%b expected 00", irq_l);
      end
      btn[0] = 1'b1;
      repeat (6) tick();
      for (int t = 0; t < 20; t++) begin
         checks++;
         if (irq_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL level_hold t=%0d: irq[0]=%b expected 1", t, irq_l[0]);
         end
         tick();
      end
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      checks++;
      if (irq_l[0] !== 1'b0) begin
         errors++;
         $display("FAIL level_ack: irq[0]=%b expected 0", irq_l[0]);
      end
      btn[0] = 1'b0;
      repeat (8) tick();
      btn[0] = 1'b1;
      repeat (5) tick();
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      checks++;
      if (irq_l[0] !== 1'b1 || btn_o_l[0] !== 1'b1) begin
         errors++;
         $display("FAIL level_ack_vs_rise: irq[0]=%b btn_o[0]=%b expected 1 1",
                  irq_l[0], btn_o_l[0]);
      end
      repeat (3) tick();
      checks++;
      if (irq_l[0] !== 1'b1) begin
         errors++;
         $display("FAIL level_ack_vs_rise_hold: irq[0]=%b expected 1", irq_l[0]);
      end
   endtask

   task automatic test_switches();
      sw = '0;
      repeat (3) tick();
      sw = 16'hA5C3;
      tick();
      checks++;
      if (sw_o_p !== 16'h0000 || sw_o_l !== 16'h0000) begin
         errors++;
         $display("FAIL sw_early: sw_o=%h expected 0000", sw_o_p);
      end
      tick();
      checks++;
      if (sw_o_p !== 16'hA5C3 || sw_o_l !== 16'hA5C3) begin
         errors++;
         $display("FAIL sw_latency: sw_o=%h expected a5c3", sw_o_p);
      end
   endtask

   task automatic test_reset_interplay();
      pll = 1'b0;
      repeat (3) tick();
      btn[0] = 1'b0;
      repeat (8) tick();
      checks++;
      if (srst_p !== 1'b1 || btn_o_p[0] !== 1'b0) begin
         errors++;
         $display("FAIL srst_release: srst=%b btn_o[0]=%b expected 1 0", srst_p, btn_o_p[0]);
      end
      btn[0] = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         checks++;
         if ({irq_p, irq_l} !== '0) begin
            errors++;
            $display("FAIL srst_press_irq t=%0d: irq=%b/%b expected 00/00", t, irq_p, irq_l);
         end
      end
      checks++;
      if (btn_o_p[0] !== 1'b1 || btn_o_l[0] !== 1'b1) begin
         errors++;
         $display("FAIL srst_press_btn: btn_o[0]=%b/%b expected 1", btn_o_p[0], btn_o_l[0]);
      end
      pll = 1'b1;
      btn[0] = 1'b0;
      repeat (3) tick();
      arstn = 1'b0;
      #1;
      checks++;
      if ({srst_p, srst_l} !== 2'b11 ||
          {btn_o_p, btn_o_l, irq_p, irq_l, sw_o_p, sw_o_l} !== '0) begin
         errors++;
         $display("FAIL async_abort: srst=%b btn=%b irq=%b sw=%h expected 1 0 0 0",
                  srst_p, btn_o_p, irq_p, sw_o_p);
      end
   endtask

   task automatic test_random();
      do_reset(1'b1);
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NB; i++) if ($urandom_range(7) == 0) btn[i] = ~btn[i];
         sw  = NS'($urandom);
         ack = ($urandom_range(3) == 0) ? NB'($urandom) : '0;
         if (c % 300 == 150) pll = 1'b0;
         if (c % 300 == 150 + (c / 300) + 1) pll = 1'b1;
         tick();
         checks++;
         if ({srst_p, btn_o_p, irq_p, sw_o_p} !== {m_srst, m_stable, m_irq_p, m_sw}) begin
            errors++;
            $display("FAIL rand_pulse c=%0d: srst=%b btn=%b irq=%b sw=%h exp %b %b %b %h",
                     c, srst_p, btn_o_p, irq_p, sw_o_p, m_srst, m_stable, m_irq_p, m_sw);
         end
         checks++;
         if ({srst_l, btn_o_l, irq_l, sw_o_l} !== {m_srst, m_stable, m_irq_l, m_sw}) begin
            errors++;
            $display("FAIL rand_level c=%0d: srst=%b btn=%b irq=%b sw=%h exp %b %b %b %h",
                     c, srst_l, btn_o_l, irq_l, sw_o_l, m_srst, m_stable, m_irq_l, m_sw);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock_timing();
      test_clean_press();
      test_bounce();
      test_level();
      test_switches();
      test_reset_interplay();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
